// File: rtl/arac_pkg.sv
// rtl/arac_pkg.sv - shared direction codes, alarm state type and pair collision rule
//
// Purpose : constants and types shared by the vehicle collision monitor.
//   ILERI/SOL/SAG/DUR : 2-bit direction codes, {solbit,sagbit}
//   durum_t           : alarm FSM state (IZLE, ALARM)
//   cift_carpar()     : collision rule for one front/behind vehicle pair
package arac_pkg;

  localparam logic [1:0] ILERI = 2'b00;
  localparam logic [1:0] SOL   = 2'b10;
  localparam logic [1:0] SAG   = 2'b01;
  localparam logic [1:0] DUR   = 2'b11;

  typedef enum logic {
    IZLE  = 1'b0,
    ALARM = 1'b1
  } durum_t;

  // Two vehicles steering the same way (other than straight) meet, and a
  // vehicle driving straight into a stopped vehicle behind it also counts.
  function automatic logic cift_carpar(logic [1:0] on_yon, logic [1:0] arka_yon);
    return ((on_yon == arka_yon) && (on_yon != ILERI)) ||
           ((on_yon == ILERI) && (arka_yon == DUR));
  endfunction

endpackage

// File: rtl/yon_cozucu.sv
// rtl/yon_cozucu.sv - per-vehicle direction decoder
//
// Purpose : turns one vehicle's three obstacle sensors into a direction code.
// Ports   :
//   on_i, sol_i, sag_i : front/left/right sensor, 1 = blocked
//   yon_o              : ILERI when front is free, else SOL, else SAG, else DUR
module yon_cozucu
  import arac_pkg::*;
(
  input  logic       on_i,
  input  logic       sol_i,
  input  logic       sag_i,
  output logic [1:0] yon_o
);

  always_comb begin
    yon_o = DUR;
    if (!on_i) begin
      yon_o = ILERI;
    end else if (!sol_i) begin
      yon_o = SOL;
    end else if (!sag_i) begin
      yon_o = SAG;
    end
  end

endmodule

// File: rtl/arac_carpisma_izleyici.sv
// rtl/arac_carpisma_izleyici.sv - single-lane vehicle collision monitor with alarm
//
// Purpose : decodes per-vehicle directions, flags colliding neighbour pairs,
//           counts collision events and holds an alarm for ALARM_SURE cycles.
// Ports   :
//   clk, rst          : clock, synchronous active-high reset
//   gecerli           : sensor sample strobe
//   sag, sol, on      : per-vehicle right/left/front sensors (index 0 = front)
//   onay              : operator acknowledge, ends an active alarm
//   yon, yon_gecerli  : registered directions and their update strobe
//   cift_carpisma     : registered pair flags, bit i = vehicles i and i+1
//   carpisti_mi       : OR of the pair flags
//   alarm             : alarm FSM is in ALARM
//   carpisma_sayisi   : saturating collision event count
module arac_carpisma_izleyici
  import arac_pkg::*;
#(
  parameter int N_ARAC     = 4,
  parameter int ALARM_SURE = 8,
  parameter int SAYAC_W    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  gecerli,
  input  logic [N_ARAC-1:0]     sag,
  input  logic [N_ARAC-1:0]     sol,
  input  logic [N_ARAC-1:0]     on,
  input  logic                  onay,
  output logic [2*N_ARAC-1:0]   yon,
  output logic                  yon_gecerli,
  output logic [N_ARAC-2:0]     cift_carpisma,
  output logic                  carpisti_mi,
  output logic                  alarm,
  output logic [SAYAC_W-1:0]    carpisma_sayisi
);

  localparam logic [7:0] SURE = 8'(ALARM_SURE);

  logic [2*N_ARAC-1:0] yon_cozulmus;
  logic [N_ARAC-2:0]   cift_yeni;

  logic [2*N_ARAC-1:0] yon_q, yon_d;
  logic                yon_gecerli_q, yon_gecerli_d;
  logic [N_ARAC-2:0]   cift_q, cift_d;
  logic                olay_q, olay_d;
  logic [SAYAC_W-1:0]  sayi_q, sayi_d;

  durum_t              durum_q;
  logic [7:0]          tutma_q;
  logic                alarm_q;

  genvar g;
  for (g = 0; g < N_ARAC; g++) begin : g_cozucu
    yon_cozucu u_yon_cozucu (
      .on_i  (on[g]),
      .sol_i (sol[g]),
      .sag_i (sag[g]),
      .yon_o (yon_cozulmus[2*g +: 2])
    );
  end

  always_comb begin
    cift_yeni = '0;
    for (int i = 0; i < N_ARAC - 1; i++) begin
      cift_yeni[i] = cift_carpar(yon_q[2*i +: 2], yon_q[2*i+2 +: 2]);
    end

    yon_d         = gecerli ? yon_cozulmus : yon_q;
    yon_gecerli_d = gecerli;

    cift_d = cift_q;
    olay_d = 1'b0;
    if (yon_gecerli_q) begin
      cift_d = cift_yeni;
      // Only rising pair bits make an event, so a lingering collision
      // is counted once no matter how many samples confirm it.
      olay_d = |(cift_yeni & ~cift_q);
    end

    sayi_d = sayi_q;
    if (olay_q && (sayi_q != '1)) begin
      sayi_d = sayi_q + SAYAC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      yon_q         <= '0;
      yon_gecerli_q <= 1'b0;
      cift_q        <= '0;
      olay_q        <= 1'b0;
      sayi_q        <= '0;
    end else begin
      yon_q         <= yon_d;
      yon_gecerli_q <= yon_gecerli_d;
      cift_q        <= cift_d;
      olay_q        <= olay_d;
      sayi_q        <= sayi_d;
    end
  end

  // Alarm FSM. A new event always beats onay so a fresh collision is never
  // silenced by an acknowledge aimed at the previous one.
  always_ff @(posedge clk) begin
    if (rst) begin
      durum_q <= IZLE;
      tutma_q <= '0;
      alarm_q <= 1'b0;
    end else begin
      case (durum_q)
        IZLE: begin
          if (olay_q) begin
            durum_q <= ALARM;
            tutma_q <= SURE;
            alarm_q <= 1'b1;
          end
        end
        ALARM: begin
          if (olay_q) begin
            tutma_q <= SURE;
          end else if (onay || (tutma_q <= 8'd1)) begin
            durum_q <= IZLE;
            tutma_q <= '0;
            alarm_q <= 1'b0;
          end else begin
            tutma_q <= tutma_q - 8'd1;
          end
        end
        default: begin
          durum_q <= IZLE;
          tutma_q <= '0;
          alarm_q <= 1'b0;
        end
      endcase
    end
  end

  assign yon             = yon_q;
  assign yon_gecerli     = yon_gecerli_q;
  assign cift_carpisma   = cift_q;
  assign carpisti_mi     = |cift_q;
  assign alarm           = alarm_q;
  assign carpisma_sayisi = sayi_q;

endmodule

// File: tb/tb_arac_carpisma_izleyici.sv
// tb/tb_arac_carpisma_izleyici.sv - self-checking bench for arac_carpisma_izleyici
module tb_arac_carpisma_izleyici;

  localparam int N  = 3;
  localparam int AS = 4;
  localparam int W  = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           gecerli;
  logic [N-1:0]   sag, sol, on;
  logic           onay;
  logic [2*N-1:0] yon;
  logic           yon_gecerli;
  logic [N-2:0]   cift_carpisma;
  logic           carpisti_mi;
  logic           alarm;
  logic [W-1:0]   carpisma_sayisi;

  typedef struct {
    logic [2*N-1:0] yon;
    logic [N-2:0]   pairs;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  arac_carpisma_izleyici #(.N_ARAC(N), .ALARM_SURE(AS), .SAYAC_W(W)) dut (
    .clk             (clk),
    .rst             (rst),
    .gecerli         (gecerli),
    .sag             (sag),
    .sol             (sol),
    .on              (on),
    .onay            (onay),
    .yon             (yon),
    .yon_gecerli     (yon_gecerli),
    .cift_carpisma   (cift_carpisma),
    .carpisti_mi     (carpisti_mi),
    .alarm           (alarm),
    .carpisma_sayisi (carpisma_sayisi)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] ref_dir(logic o, logic l, logic r);
    if (!o) return 2'b00;
    if (!l) return 2'b10;
    if (!r) return 2'b01;
    return 2'b11;
  endfunction

  function automatic logic [N-2:0] ref_pairs(logic [2*N-1:0] y);
    logic [N-2:0] p;
    logic [1:0]   f, b;
    p = '0;
    for (int i = 0; i < N - 1; i++) begin
      f = y[2*i +: 2];
      b = y[2*i+2 +: 2];
      p[i] = (f != 2'b00 && f == b) || (f == 2'b00 && b == 2'b11);
    end
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [N-1:0] o, input logic [N-1:0] l, input logic [N-1:0] r);
    exp_t e;
    on = o; sol = l; sag = r; gecerli = 1'b1;
    for (int i = 0; i < N; i++) e.yon[2*i +: 2] = ref_dir(o[i], l[i], r[i]);
    e.pairs = ref_pairs(e.yon);
    sb.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b1; gecerli = 1'b0; onay = 1'b0;
    tick();
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; gecerli = 1'b0; onay = 1'b0; on = '0; sol = '0; sag = '0;
    tick(); tick();
    checks++; if (yon !== '0) begin errors++; $display("FAIL reset_yon got %0h want 0", yon); end
    checks++; if (yon_gecerli !== 1'b0) begin errors++; $display("FAIL reset_yon_gecerli got %0b want 0", yon_gecerli); end
    checks++; if (cift_carpisma !== '0) begin errors++; $display("FAIL reset_cift got %0b want 0", cift_carpisma); end
    checks++; if (carpisti_mi !== 1'b0) begin errors++; $display("FAIL reset_carpisti got %0b want 0", carpisti_mi); end
    checks++; if (alarm !== 1'b0) begin errors++; $display("FAIL reset_alarm got %0b want 0", alarm); end
    checks++; if (carpisma_sayisi !== '0) begin errors++; $display("FAIL reset_sayi got %0d want 0", carpisma_sayisi); end
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic test_ileri();
    exp_t e;
    send(3'b000, 3'($urandom), 3'($urandom));
    tick();
    gecerli = 1'b0;
    e = sb.pop_front();
    checks++; if (yon_gecerli !== 1'b1) begin errors++; $display("FAIL ileri_yon_gecerli got %0b want 1", yon_gecerli); end
    checks++; if (yon !== e.yon) begin errors++; $display("FAIL ileri_yon got %0h want %0h", yon, e.yon); end
    tick();
    checks++; if (yon_gecerli !== 1'b0) begin errors++; $display("FAIL ileri_yon_gecerli_low got %0b want 0", yon_gecerli); end
    checks++; if (cift_carpisma !== e.pairs) begin errors++; $display("FAIL ileri_cift got %0b want %0b", cift_carpisma, e.pairs); end
    checks++; if (carpisti_mi !== 1'b0) begin errors++; $display("FAIL ileri_carpisti got %0b want 0", carpisti_mi); end
    tick();
    checks++; if (alarm !== 1'b0 || carpisma_sayisi !== '0) begin errors++; $display("FAIL ileri_alarm_sayi got %0b/%0d want 0/0", alarm, carpisma_sayisi); end
  endtask

  task automatic test_collision_alarm();
    exp_t e;
    int   hi;
    send(3'b010, 3'b010, 3'b010);
    tick();
    gecerli = 1'b0;
    e = sb.pop_front();
    checks++; if (yon !== e.yon) begin errors++; $display("FAIL col_yon got %0h want %0h", yon, e.yon); end
    tick();
    checks++; if (cift_carpisma !== e.pairs) begin errors++; $display("FAIL col_cift got %0b want %0b", cift_carpisma, e.pairs); end
    checks++; if (carpisti_mi !== 1'b1) begin errors++; $display("FAIL col_carpisti got %0b want 1", carpisti_mi); end
    checks++; if (alarm !== 1'b0) begin errors++; $display("FAIL col_alarm_early got %0b want 0", alarm); end
    tick();
    checks++; if (alarm !== 1'b1) begin errors++; $display("FAIL col_alarm got %0b want 1", alarm); end
    checks++; if (carpisma_sayisi !== 2'd1) begin errors++; $display("FAIL col_sayi got %0d want 1", carpisma_sayisi); end
    hi = alarm ? 1 : 0;
    for (int k = 0; k < 40 && alarm; k++) begin
      tick();
      if (alarm) hi++;
    end
    checks++; if (hi !== AS) begin errors++; $display("FAIL col_alarm_len got %0d want %0d", hi, AS); end
    checks++; if (alarm !== 1'b0) begin errors++; $display("FAIL col_alarm_drop got %0b want 0", alarm); end
    checks++; if (carpisti_mi !== 1'b1 || carpisma_sayisi !== 2'd1) begin errors++; $display("FAIL col_persist got %0b/%0d want 1/1", carpisti_mi, carpisma_sayisi); end
    // Same collision again plus an onay while idle: neither may re-arm.
    send(3'b010, 3'b010, 3'b010);
    tick();
    gecerli = 1'b0;
    onay = 1'b1;
    void'(sb.pop_front());
    tick();
    onay = 1'b0;
    tick(); tick();
    checks++; if (alarm !== 1'b0 || carpisma_sayisi !== 2'd1) begin errors++; $display("FAIL col_no_rearm got %0b/%0d want 0/1", alarm, carpisma_sayisi); end
  endtask

  task automatic test_onay_reload();
    exp_t e;
    int   hi;
    send(3'b000, 3'b000, 3'b000);
    tick();
    gecerli = 1'b0;
    void'(sb.pop_front());
    tick();
    checks++; if (carpisti_mi !== 1'b0) begin errors++; $display("FAIL reload_clear got %0b want 0", carpisti_mi); end
    send(3'b010, 3'b010, 3'b010);
    tick();
    gecerli = 1'b0;
    void'(sb.pop_front());
    tick(); tick();
    checks++; if (alarm !== 1'b1 || carpisma_sayisi !== 2'd2) begin errors++; $display("FAIL reload_arm got %0b/%0d want 1/2", alarm, carpisma_sayisi); end
    send(3'b000, 3'b000, 3'b000);
    tick();
    void'(sb.pop_front());
    send(3'b110, 3'b000, 3'b000);
    tick();
    gecerli = 1'b0;
    e = sb.pop_front();
    tick();
    onay = 1'b1;
    tick();
    onay = 1'b0;
    checks++; if (cift_carpisma !== e.pairs) begin errors++; $display("FAIL reload_cift got %0b want %0b", cift_carpisma, e.pairs); end
    checks++; if (alarm !== 1'b1) begin errors++; $display("FAIL reload_alarm got %0b want 1", alarm); end
    checks++; if (carpisma_sayisi !== 2'd3) begin errors++; $display("FAIL reload_sayi got %0d want 3", carpisma_sayisi); end
    hi = alarm ? 1 : 0;
    for (int k = 0; k < 40 && alarm; k++) begin
      tick();
      if (alarm) hi++;
    end
    checks++; if (hi !== AS) begin errors++; $display("FAIL reload_len got %0d want %0d", hi, AS); end
  endtask

  task automatic test_back_to_back();
    exp_t         e;
    logic [N-2:0] pend, prev;
    logic         pend_v;
    int           events;
    do_reset();
    pend = '0; prev = '0; pend_v = 1'b0; events = 0;
    for (int i = 0; i < 12; i++) begin
      if (i < 10) send(3'($urandom), 3'($urandom), 3'($urandom));
      else gecerli = 1'b0;
      tick();
      if (pend_v) begin
        checks++; if (cift_carpisma !== pend) begin errors++; $display("FAIL b2b_cift[%0d] got %0b want %0b", i, cift_carpisma, pend); end
      end
      checks++; if (yon_gecerli !== (i < 10)) begin errors++; $display("FAIL b2b_yon_gecerli[%0d] got %0b want %0b", i, yon_gecerli, i < 10); end
      if (i < 10) begin
        e = sb.pop_front();
        checks++; if (yon !== e.yon) begin errors++; $display("FAIL b2b_yon[%0d] got %0h want %0h", i, yon, e.yon); end
        if ((e.pairs & ~prev) != '0) events++;
        prev = e.pairs; pend = e.pairs; pend_v = 1'b1;
      end else begin
        pend_v = 1'b0;
      end
    end
    gecerli = 1'b0;
    tick();
    checks++; if (carpisma_sayisi !== W'(events > 3 ? 3 : events)) begin errors++; $display("FAIL b2b_sayi got %0d want %0d", carpisma_sayisi, events > 3 ? 3 : events); end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      send(3'b010, 3'b010, 3'b010);
      tick();
      send(3'b000, 3'b000, 3'b000);
      tick();
    end
    gecerli = 1'b0;
    tick(); tick(); tick();
    sb.delete();
    checks++; if (carpisma_sayisi !== 2'd3) begin errors++; $display("FAIL sat_sayi got %0d want 3", carpisma_sayisi); end
  endtask

  task automatic test_reset_midpipe();
    do_reset();
    send(3'b010, 3'b010, 3'b010);
    tick();
    rst = 1'b1;
    send(3'b010, 3'b010, 3'b010);
    tick();
    rst = 1'b0;
    gecerli = 1'b0;
    sb.delete();
    checks++; if (yon !== '0 || yon_gecerli !== 1'b0) begin errors++; $display("FAIL mid_yon got %0h/%0b want 0/0", yon, yon_gecerli); end
    checks++; if (cift_carpisma !== '0 || carpisti_mi !== 1'b0) begin errors++; $display("FAIL mid_cift got %0b/%0b want 0/0", cift_carpisma, carpisti_mi); end
    tick(); tick(); tick(); tick();
    checks++; if (carpisti_mi !== 1'b0 || yon_gecerli !== 1'b0) begin errors++; $display("FAIL mid_later got %0b/%0b want 0/0", carpisti_mi, yon_gecerli); end
    checks++; if (alarm !== 1'b0 || carpisma_sayisi !== '0) begin errors++; $display("FAIL mid_alarm_sayi got %0b/%0d want 0/0", alarm, carpisma_sayisi); end
  endtask

  initial begin
    rst = 1'b1; gecerli = 1'b0; onay = 1'b0; on = '0; sol = '0; sag = '0;
    test_reset();
    test_ileri();
    test_collision_alarm();
    test_onay_reload();
    test_back_to_back();
    test_saturation();
    test_reset_midpipe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
